// File: rtl/red_pitaya_bus_initiator_if.sv
// Command, register-bus and response signals of the bus initiator.
// master = initiator view, slave = surrounding logic and responder view.
interface red_pitaya_bus_initiator_if #(
   parameter int ADDRBITS = 16,
   parameter int DATABITS = 32
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_write;
   logic [ADDRBITS-1:0] cmd_addr;
   logic [DATABITS-1:0] cmd_wdata;
   logic [ADDRBITS-1:0] addr;
   logic                wen;
   logic                ren;
   logic [DATABITS-1:0] wdata;
   logic                ack;
   logic [DATABITS-1:0] rdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATABITS-1:0] rsp_rdata;
   logic                rsp_err;
   logic                busy;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  ack, rdata, rsp_ready,
      output cmd_ready, addr, wen, ren, wdata,
      output rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output ack, rdata, rsp_ready,
      input  cmd_ready, addr, wen, ren, wdata,
      input  rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/red_pitaya_bus_initiator.sv
// Single-outstanding initiator for the sub-block register bus:
// one strobe per command, ack or timeout, then a held response.
module red_pitaya_bus_initiator #(
   parameter int ADDRBITS = 16,
   parameter int DATABITS = 32,
   parameter int TIMEOUT  = 16
) (
   input logic clk_i,
   input logic rstn_i,
   red_pitaya_bus_initiator_if.master bus_if
);

   localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      WAIT,
      RESP
   } state_e;

   state_e              state_q, state_d;
   logic [ADDRBITS-1:0] addr_q,  addr_d;
   logic [DATABITS-1:0] wdata_q, wdata_d;
   logic                dir_q,   dir_d;
   logic [7:0]          cnt_q,   cnt_d;
   logic [DATABITS-1:0] rdata_q, rdata_d;
   logic                err_q,   err_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus_if.cmd_valid) begin
               addr_d  = bus_if.cmd_addr;
               wdata_d = bus_if.cmd_wdata;
               dir_d   = bus_if.cmd_write;
               state_d = STROBE;
            end
         end
         STROBE: begin
            cnt_d   = TO_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            // ack wins over an expiring counter in the same cycle
            if (bus_if.ack) begin
               rdata_d = dir_q ? '0 : bus_if.rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == 8'd1) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESP: begin
            if (bus_if.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus_if.cmd_ready = (state_q == IDLE);
   assign bus_if.busy      = (state_q != IDLE);
   assign bus_if.wen       = (state_q == STROBE) &&  dir_q;
   assign bus_if.ren       = (state_q == STROBE) && !dir_q;
   assign bus_if.addr      = addr_q;
   assign bus_if.wdata     = wdata_q;
   assign bus_if.rsp_valid = (state_q == RESP);
   assign bus_if.rsp_rdata = rdata_q;
   assign bus_if.rsp_err   = err_q;

endmodule
